regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised multi-register file; successor to the single 16-bit write-enabled register.
- One write port with byte enables and two asynchronous read ports.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register busy scoreboard, so the single-cycle core (and later pipelined variants) can detect pending writebacks.

Parameters:
- DATA_W, 16, register width in bits; must be a multiple of 8.
- ADDR_W, 3, address width; register count NREG = 2**ADDR_W.
- R0_ZERO, 1, 1 = register 0 reads as 0, ignores writes and never goes busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  DATA_W  read data, port A.
- raddr_b  in  ADDR_W  read address, port B.
- rdata_b  out  DATA_W  read data, port B.
- sb_set  in  1  mark register sb_addr busy (instruction issued).
- sb_addr  in  ADDR_W  scoreboard set address.
- busy_a  out  1  busy bit of raddr_a.
- busy_b  out  1  busy bit of raddr_b.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Storage: NREG x DATA_W flops plus an NREG-bit busy vector; no RAM inference.
- Reset:
  - rst=1 at a clock edge clears every register to 0 and every busy bit to 0.
  - rst dominates we and sb_set in that cycle.
  - Outputs then read 0: rdata_a/b=0 unless bypassed, busy_a/b=0, any_busy=0.
  - Before the first reset edge, contents are unspecified.
- Write:
  - On an edge with we=1, for each i with wbe[i]=1, reg[waddr] byte i <= wdata byte i.
  - Bytes with wbe[i]=0 hold their value.
  - we=1 with wbe all-zero changes no data but still clears busy (below).
- Read: combinational, zero-latency. rdata_x = reg[raddr_x].
- Bypass (BYPASS=1):
  - Applies when we=1 and waddr==raddr_x (and not the zero register).
  - rdata_x = byte-merge of wdata (enabled bytes) and reg[raddr_x] (disabled bytes), i.e. the post-edge value.
  - Applies independently to A and B; both may bypass at once.
  - BYPASS=0: reads return pre-edge contents.
- Zero register (R0_ZERO=1):
  - Address 0 reads 0 on both ports, including bypass.
  - Writes to address 0 are dropped.
  - sb_set to address 0 is ignored; busy_x for address 0 is always 0.
  - R0_ZERO=0: register 0 is ordinary.
- Scoreboard, per edge (rst=0):
  - we=1 clears busy[waddr].
  - sb_set=1 sets busy[sb_addr].
  - Same address with both: set wins (a new producer issued the same cycle the old one wrote back).
  - Different addresses: both take effect.
  - busy_a/busy_b/any_busy are combinational from the registered busy vector. No bypass of sb_set: a same-cycle set is visible next cycle.
- Latency:
  - Write visible to reads the cycle after the edge, or the same cycle with BYPASS=1.
  - Busy change visible the cycle after the edge.
- Reset mid-operation: a pending write or sb_set in the reset cycle is discarded.
- Boundaries:
  - waddr = NREG-1 is a legal address; addresses never wrap or alias.
  - Simultaneous read of the same address on A and B returns identical data.

Test Plan:
1. Reset then read all 8 registers on both ports -> every rdata=0x0000, busy_a=busy_b=any_busy=0.
2. we=1, waddr=3, wdata=0xBEEF, wbe=2'b11; next cycle raddr_a=3 -> rdata_a=0xBEEF. Then wbe=2'b01, wdata=0x1234 -> rdata_a=0xBE34.
3. BYPASS=1: same cycle we=1, waddr=5, wdata=0xA5A5, wbe=2'b10, raddr_a=raddr_b=5, old reg5=0x0011 -> rdata_a=rdata_b=0xA511 before the edge. Repeat with BYPASS=0 -> 0x0011.
4. R0_ZERO=1: write 0xFFFF to addr 0 and sb_set at addr 0 -> rdata_a(addr 0)=0x0000 same and next cycle, busy_a=0, any_busy=0.
5. Scoreboard:
   - sb_set addr 6 -> busy=1 next cycle, any_busy=1.
   - we=1 waddr=6 with sb_set addr 6 same edge -> busy stays 1.
   - we=1 waddr=6 alone -> busy=0, any_busy=0.
6. Reg7=0x7777 and busy[7]=1; assert rst together with we=1 waddr=7 wdata=0x1111 -> next cycle rdata(7)=0x0000, busy=0.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: one byte-enabled write port, two async
// read ports, optional write bypass, optional zero r0, busy scoreboard.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   we, waddr, wdata, wbe write port with per-byte enables
//   raddr_a/b, rdata_a/b  combinational read ports
//   sb_set, sb_addr       mark a register busy (producer issued)
//   busy_a/b, any_busy    busy bit of each read address, OR of all
module regfile_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0]   raddr_a,
  output logic [DATA_W-1:0]   rdata_a,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic [DATA_W-1:0]   rdata_b,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_addr,
  output logic                busy_a,
  output logic                busy_b,
  output logic                any_busy
);

  localparam int NREG = 1 << ADDR_W;
  localparam int NB   = DATA_W / 8;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  logic              wr_ok;
  logic              sb_ok;
  logic [DATA_W-1:0] wmerge;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return R0_ZERO && (a == '0);
  endfunction

  // Post-edge value of the write target: enabled bytes from wdata,
  // the rest held from the current contents.
  always_comb begin
    wmerge = rf_q[waddr];
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) begin
        wmerge[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  assign wr_ok = we && !is_zero(waddr);
  assign sb_ok = sb_set && !is_zero(sb_addr);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      rf_d[r] = rf_q[r];
    end
    busy_d = busy_q;
    if (wr_ok) begin
      rf_d[waddr]   = wmerge;
      busy_d[waddr] = 1'b0;
    end
    // Applied after the clear so a same-address issue wins.
    if (sb_ok) begin
      busy_d[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= rf_d[r];
      end
      busy_q <= busy_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd(
    input logic [ADDR_W-1:0] a
  );
    if (is_zero(a)) begin
      return '0;
    end else if (BYPASS && we && (a == waddr)) begin
      return wmerge;
    end else begin
      return rf_q[a];
    end
  endfunction

  assign rdata_a  = rd(raddr_a);
  assign rdata_b  = rd(raddr_b);
  assign busy_a   = busy_q[raddr_a] && !is_zero(raddr_a);
  assign busy_b   = busy_q[raddr_b] && !is_zero(raddr_b);
  assign any_busy = |busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a bypassing instance and a
// non-bypassing instance share one stimulus stream.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic        sb_set;
  logic [2:0]  sb_addr;

  logic [15:0] rdata_a, rdata_b, rdata_a0, rdata_b0;
  logic        busy_a, busy_b, any_busy;
  logic        busy_a0, busy_b0, any_busy0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_param #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .rdata_a(rdata_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_a(busy_a), .busy_b(busy_b), .any_busy(any_busy)
  );

  regfile_param #(.BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .rdata_a(rdata_a0),
    .raddr_b(raddr_b), .rdata_b(rdata_b0),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_a(busy_a0), .busy_b(busy_b0), .any_busy(any_busy0)
  );

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [1:0]  wbe;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        sb;
    logic [2:0]  sa;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] ea0;
    logic [15:0] eb0;
    logic        ba;
    logic        bb;
    logic        any;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
    input logic we_, input logic [2:0] wa, input logic [15:0] wd,
    input logic [1:0] be, input logic [2:0] ra, input logic [2:0] rb,
    input logic sb, input logic [2:0] sa,
    input logic [15:0] ea, input logic [15:0] eb,
    input logic [15:0] ea0, input logic [15:0] eb0,
    input logic ba, input logic bb, input logic an
  );
    vec_t v;
    v.we = we_; v.wa = wa; v.wd = wd; v.wbe = be;
    v.ra = ra; v.rb = rb; v.sb = sb; v.sa = sa;
    v.ea = ea; v.eb = eb; v.ea0 = ea0; v.eb0 = eb0;
    v.ba = ba; v.bb = bb; v.any = an;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic chk_busy(input int idx, input logic ba,
                          input logic bb, input logic an);
    chk("busy_a", idx, {15'd0, busy_a}, {15'd0, ba});
    chk("busy_b", idx, {15'd0, busy_b}, {15'd0, bb});
    chk("any_busy", idx, {15'd0, any_busy}, {15'd0, an});
    chk("busy_a0", idx, {15'd0, busy_a0}, {15'd0, ba});
    chk("busy_b0", idx, {15'd0, busy_b0}, {15'd0, bb});
    chk("any_busy0", idx, {15'd0, any_busy0}, {15'd0, an});
  endtask

  initial begin
    //             we wa  wd        be     ra rb sb sa  ea        eb        ea0       eb0      ba bb any
    tbl[0]  = mk(1, 3, 16'hBEEF, 2'b11, 3, 3, 0, 0, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(1, 3, 16'h1234, 2'b01, 3, 0, 0, 0, 16'hBE34, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 2'b00, 3, 3, 0, 0, 16'hBE34, 16'hBE34, 16'hBE34, 16'hBE34, 0, 0, 0);
    tbl[3]  = mk(1, 5, 16'h0011, 2'b11, 7, 7, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[4]  = mk(1, 5, 16'hA5A5, 2'b10, 5, 5, 0, 0, 16'hA511, 16'hA511, 16'h0011, 16'h0011, 0, 0, 0);
    tbl[5]  = mk(0, 0, 16'h0000, 2'b00, 5, 3, 0, 0, 16'hA511, 16'hBE34, 16'hA511, 16'hBE34, 0, 0, 0);
    tbl[6]  = mk(1, 0, 16'hFFFF, 2'b11, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[7]  = mk(0, 0, 16'h0000, 2'b00, 0, 5, 0, 0, 16'h0000, 16'hA511, 16'h0000, 16'hA511, 0, 0, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 2'b00, 6, 6, 1, 6, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[9]  = mk(1, 6, 16'h0600, 2'b11, 6, 0, 1, 6, 16'h0600, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1);
    tbl[10] = mk(1, 6, 16'h0066, 2'b01, 6, 6, 0, 0, 16'h0666, 16'h0666, 16'h0600, 16'h0600, 1, 1, 1);
    tbl[11] = mk(0, 0, 16'h0000, 2'b00, 6, 7, 0, 0, 16'h0666, 16'h0000, 16'h0666, 16'h0000, 0, 0, 0);
    tbl[12] = mk(1, 7, 16'h7777, 2'b11, 7, 7, 1, 7, 16'h7777, 16'h7777, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[13] = mk(0, 0, 16'h0000, 2'b00, 7, 2, 1, 2, 16'h7777, 16'h0000, 16'h7777, 16'h0000, 1, 0, 1);
    tbl[14] = mk(1, 2, 16'h0202, 2'b00, 2, 7, 0, 0, 16'h0000, 16'h7777, 16'h0000, 16'h7777, 1, 1, 1);
    tbl[15] = mk(0, 0, 16'h0000, 2'b00, 2, 7, 0, 0, 16'h0000, 16'h7777, 16'h0000, 16'h7777, 0, 1, 1);

    idle();
    raddr_a = '0; raddr_b = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Every register reads zero and idle after reset.
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      raddr_b = 3'(7 - i);
      #1;
      chk("rst_rdata_a", i, rdata_a, 16'h0000);
      chk("rst_rdata_b", i, rdata_b, 16'h0000);
      chk("rst_rdata_a0", i, rdata_a0, 16'h0000);
      chk("rst_rdata_b0", i, rdata_b0, 16'h0000);
      chk_busy(100 + i, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Table: inputs held for one cycle, outputs checked before the edge.
    for (int i = 0; i < 16; i++) begin
      we = tbl[i].we; waddr = tbl[i].wa;
      wdata = tbl[i].wd; wbe = tbl[i].wbe;
      raddr_a = tbl[i].ra; raddr_b = tbl[i].rb;
      sb_set = tbl[i].sb; sb_addr = tbl[i].sa;
      #1;
      chk("rdata_a", i, rdata_a, tbl[i].ea);
      chk("rdata_b", i, rdata_b, tbl[i].eb);
      chk("rdata_a_nobyp", i, rdata_a0, tbl[i].ea0);
      chk("rdata_b_nobyp", i, rdata_b0, tbl[i].eb0);
      chk_busy(i, tbl[i].ba, tbl[i].bb, tbl[i].any);
      @(negedge clk);
    end

    // Reset with a pending write and issue: both discarded.
    // Entering here reg7=7777, busy7=1, reg3=BE34.
    idle();
    rst = 1'b1;
    we = 1'b1; waddr = 3'd7; wdata = 16'h1111; wbe = 2'b11;
    sb_set = 1'b1; sb_addr = 3'd3;
    raddr_a = 3'd7; raddr_b = 3'd3;
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("mid_rst_rdata_a", 200, rdata_a, 16'h0000);
    chk("mid_rst_rdata_b", 200, rdata_b, 16'h0000);
    chk("mid_rst_rdata_a0", 200, rdata_a0, 16'h0000);
    chk_busy(200, 1'b0, 1'b0, 1'b0);

    // Top address write, then same-address dual read after the edge.
    we = 1'b1; waddr = 3'd7; wdata = 16'hC3A7; wbe = 2'b11;
    raddr_a = 3'd7; raddr_b = 3'd7;
    @(negedge clk);
    idle();
    #1;
    chk("top_rdata_a", 201, rdata_a, 16'hC3A7);
    chk("top_rdata_b", 201, rdata_b, 16'hC3A7);
    chk("top_rdata_a0", 201, rdata_a0, 16'hC3A7);
    chk("top_rdata_b0", 201, rdata_b0, 16'hC3A7);
    raddr_a = 3'd6;
    #1;
    chk("no_alias", 202, rdata_a, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
